// File: rtl/eco32f_divider.sv
// eco32f_divider: iterative restoring integer divider (quotient + remainder) with start/busy/done handshake
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   start        request a division, sampled only while idle
//   signed_op    1 = two's-complement operands, 0 = unsigned (sampled with start)
//   dividend     numerator (sampled with start)
//   divisor      denominator (sampled with start)
//   abort        pipeline flush, cancels any operation in progress
//   busy         operation in progress (stall request)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until the next completed operation
//   remainder    registered remainder, sign follows the dividend
//   div_by_zero  registered, set when the completed operation had divisor == 0
//
// Optional feature macro: ECO32F_DIV_ZERO_FAST_EN
//   defined   -> a zero divisor skips the iterations and completes one edge after start
//   undefined -> a zero divisor takes the full iteration latency
module eco32f_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_rem, diff;
    logic [WIDTH-1:0] step_acc;

    always_comb begin
        a_neg = signed_op & dividend[WIDTH-1];
        b_neg = signed_op & divisor[WIDTH-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor : divisor;
    end

    // acc shifts the dividend out of its MSB and collects quotient bits in its LSB;
    // the borrow of the WIDTH+1 bit subtraction decides each quotient bit.
    always_comb begin
        step_rem = prem_q;
        step_acc = acc_q;
        diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            step_rem = {step_rem[WIDTH-1:0], step_acc[WIDTH-1]};
            step_acc = {step_acc[WIDTH-2:0], 1'b0};
            diff     = step_rem - {1'b0, dsr_q};
            if (!diff[WIDTH]) begin
                step_rem    = diff;
                step_acc[0] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start && !abort) begin
                acc_d   = a_mag;
                dsr_d   = b_mag;
                prem_d  = '0;
                cnt_d   = CW'(N);
                q_neg_d = a_neg ^ b_neg;
                r_neg_d = a_neg;
                dz_d    = divisor == '0;
                state_d = CALC;
`ifdef ECO32F_DIV_ZERO_FAST_EN
                if (divisor == '0) begin
                    prem_d  = {1'b0, a_mag};
                    state_d = FIX;
                end
`endif
            end
            CALC: if (abort) state_d = IDLE;
            else begin
                acc_d   = step_acc;
                prem_d  = step_rem;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == CW'(1) ? FIX : CALC;
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    // with a zero divisor the partial remainder holds |dividend|, so the
                    // sign restore below yields the original dividend unchanged
                    quo_d  = dz_q ? '1 : (q_neg_q ? -acc_q : acc_q);
                    rem_d  = r_neg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                    dbz_d  = dz_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_eco32f_divider.sv
// tb_eco32f_divider: randomized and directed checks of eco32f_divider against an arithmetic reference model
module tb_eco32f_divider;
    localparam int W   = 32;
    localparam int BPC = 4;
    localparam int N   = W / BPC;

    logic         clk = 1'b0;
    logic         rst, start, signed_op, abort;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    int           checks = 0;
    int           errors = 0;

    eco32f_divider #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .abort(abort),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef ECO32F_DIV_ZERO_FAST_EN
        return b == 0 ? 1 : N + 1;
`else
        return N + 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return $urandom_range(1, 15);
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge with the divider idle (or in its done cycle); returns in the done cycle.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eq, er;
        int k, el;
        model(s, a, b, eq, er);
        el = exp_lat(b);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        signed_op = $urandom_range(0, 1);
        dividend  = $urandom;
        divisor   = $urandom;
        k = 0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b want 1", tag, busy); end
        while (done !== 1'b1 && k < N + 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== el) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, k, el); end
        checks++;
        if (quotient !== eq) begin errors++; $display("FAIL %s quotient: got %h want %h (a=%h b=%h s=%b)", tag, quotient, eq, a, b, s); end
        checks++;
        if (remainder !== er) begin errors++; $display("FAIL %s remainder: got %h want %h (a=%h b=%h s=%b)", tag, remainder, er, a, b, s); end
        checks++;
        if (div_by_zero !== (b == 0)) begin errors++; $display("FAIL %s div_by_zero: got %b want %b", tag, div_by_zero, b == 0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy in done cycle: got %b want 0", tag, busy); end
    endtask

    task automatic check_idle_hold(input logic [31:0] eq, input logic [31:0] er, input string tag);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s held results: got q=%h r=%h dz=%b want q=%h r=%h dz=0", tag, quotient, remainder, div_by_zero, eq, er);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 0 || remainder !== 0) begin
            errors++;
            $display("FAIL reset values: got busy=%b done=%b dz=%b q=%h r=%h want all 0", busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle_hold(0, 0, "after_reset");
    endtask

    task automatic test_directed();
        run_div(0, 100, 7, "u100_7");
        run_div(1, 32'hFFFF_FFF9, 2, "s-7_2");
        run_div(1, 7, 32'hFFFF_FFFE, "s7_-2");
        run_div(1, 32'h8000_0000, 32'hFFFF_FFFF, "s_min_-1");
        run_div(0, 32'h8000_0000, 32'hFFFF_FFFF, "u_min_ff");
        run_div(0, 32'h1234, 0, "u_dz");
        run_div(1, 32'h1234, 0, "s_dz");
        run_div(1, 32'hFFFF_EDCC, 0, "s_neg_dz");
        run_div(0, 0, 5, "u_zero_num");
        run_div(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "s-100_-7");
        run_div(0, 32'hFFFF_FFFF, 1, "u_max_1");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_abort();
        run_div(0, 1000, 3, "pre_abort");
        @(negedge clk);
        signed_op = 0; dividend = 100; divisor = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 55; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_hold(333, 1, "abort_calc");
        begin
            bit seen = 0;
            repeat (N + 3) begin
                @(negedge clk);
                seen |= done | busy;
            end
            checks++;
            if (seen) begin errors++; $display("FAIL abort_no_done: got activity=1 want 0"); end
        end
        dividend = 100; divisor = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (N) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_hold(333, 1, "abort_fix");
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_idle_hold(333, 1, "abort_with_start");
        run_div(0, 100, 7, "post_abort");
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int k;
        signed_op = 0; dividend = 100; divisor = 7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        repeat (3) begin @(negedge clk); k++; end
        signed_op = 1; dividend = 55; divisor = 0; start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
        while (done !== 1'b1 && k < N + 10) begin @(negedge clk); k++; end
        checks++;
        if (k !== N + 1) begin errors++; $display("FAIL ignored_start latency: got %0d want %0d", k, N + 1); end
        checks++;
        if (quotient !== 14 || remainder !== 2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start result: got q=%h r=%h dz=%b want q=e r=2 dz=0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        signed_op = 0; dividend = 1000; divisor = 9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        check_idle_hold(0, 0, "reset_mid_quiet");
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 1500; i++) begin
            run_div(1'($urandom_range(0, 1)), pick(), pick(), "random");
            if ($urandom_range(0, 9) == 0) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
